// File: rtl/tempo_clock_divider.sv
// tempo_clock_divider
//   Multi-channel, runtime-programmable clock divider for beat and tempo timing.
//   Each channel counts enabled clk cycles up to its active divisor N and, on the
//   terminal count, emits a one-cycle tick and toggles a square out_clk, giving
//   an out_clk period of 2*N cycles. A new divisor is staged in pending_div and
//   only adopted at a terminal count, so out_clk never shows a runt pulse.
//   A sync pulse restarts every channel in phase.
//
//   Optional feature macro: TICK_COUNT_EN
//     defined   -> tick_cnt port with a wrapping 16-bit tick counter per channel
//     undefined -> tick_cnt port and logic are omitted
//
//   Divisor write interface: div_wr is a single-cycle strobe with no back-pressure.
//   When div_wr is high at a clk edge, div_val is captured for channel div_ch.
//   Writes to channels >= NUM_CH are silently dropped.
module tempo_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 1000000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   sync,
  input  logic                   div_wr,
  input  logic [CH_W-1:0]        div_ch,
  input  logic [CNT_W-1:0]       div_val,
  output logic [NUM_CH-1:0]      tick,
`ifdef TICK_COUNT_EN
  output logic [16*NUM_CH-1:0]   tick_cnt,
`endif
  output logic [NUM_CH-1:0]      out_clk
);

  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt         [NUM_CH];
  logic [CNT_W-1:0] active_div  [NUM_CH];
  logic [CNT_W-1:0] pending_div [NUM_CH];
  logic [CNT_W-1:0] next_div    [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] halted;

  // Decode the write per channel and form the divisor a terminal count would adopt.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c]   = div_wr && ({1'b0, div_ch} < NUM_CH_V) && (div_ch == CH_W'(c));
      next_div[c] = wr_hit[c] ? div_val : pending_div[c];
      halted[c]   = (active_div[c] == '0);
      term[c]     = !halted[c] && (cnt[c] == active_div[c] - ONE);
    end
  end

  // Per-channel divider state: reset, then sync, then terminal count / write, else hold.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!resetn) begin
        cnt[c]         <= '0;
        active_div[c]  <= DEF_DIV;
        pending_div[c] <= DEF_DIV;
        tick[c]        <= 1'b0;
        out_clk[c]     <= 1'b0;
      end else if (sync) begin
        cnt[c]         <= '0;
        active_div[c]  <= next_div[c];
        pending_div[c] <= next_div[c];
        tick[c]        <= 1'b0;
        out_clk[c]     <= 1'b0;
      end else begin
        pending_div[c] <= next_div[c];
        if (halted[c]) begin
          // A halted channel sits at zero until it is given a nonzero divisor.
          cnt[c]     <= '0;
          tick[c]    <= 1'b0;
          out_clk[c] <= 1'b0;
          if (wr_hit[c] && (div_val != '0)) begin
            active_div[c] <= div_val;
          end
        end else if (enable) begin
          if (term[c]) begin
            cnt[c]        <= '0;
            tick[c]       <= 1'b1;
            active_div[c] <= next_div[c];
            // Entering halt parks out_clk low instead of toggling.
            out_clk[c]    <= (next_div[c] == '0) ? 1'b0 : ~out_clk[c];
          end else begin
            cnt[c]  <= cnt[c] + ONE;
            tick[c] <= 1'b0;
          end
        end else begin
          tick[c] <= 1'b0;
        end
      end
    end
  end

`ifdef TICK_COUNT_EN
  // Per-channel tick counter; advances on the same edge that raises tick, wraps at 16 bits.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!resetn || sync) begin
        tick_cnt[16*c +: 16] <= 16'd0;
      end else if (!halted[c] && enable && term[c]) begin
        tick_cnt[16*c +: 16] <= tick_cnt[16*c +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tempo_clock_divider.sv
// tb_tempo_clock_divider
//   Drives directed tempo scenarios followed by randomized traffic. Each cycle the
//   driver predicts tick/out_clk (and tick_cnt when TICK_COUNT_EN is defined) from
//   a countdown-to-next-beat model and pushes them into exp_q; a monitor pops one
//   entry per clk edge and compares against the DUT.
module tb_tempo_clock_divider;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 2;
`ifdef TICK_COUNT_EN
  localparam int W = 18 * NUM_CH;
`else
  localparam int W = 2 * NUM_CH;
`endif

  logic              clk;
  logic              resetn;
  logic              enable;
  logic              sync;
  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] out_clk;
`ifdef TICK_COUNT_EN
  logic [16*NUM_CH-1:0] tick_cnt;
`endif

  tempo_clock_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .sync     (sync),
    .div_wr   (div_wr),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .tick     (tick),
`ifdef TICK_COUNT_EN
    .tick_cnt (tick_cnt),
`endif
    .out_clk  (out_clk)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    resetn  = 1'b0;
    enable  = 1'b0;
    sync    = 1'b0;
    div_wr  = 1'b0;
    div_ch  = '0;
    div_val = '0;
  end

  // ---------------- reference model ----------------
  // Each channel is described by its beat length, the next beat length, how many
  // enabled cycles remain until the next beat, the square-wave level and beat count.
  int m_len  [NUM_CH];
  int m_next [NUM_CH];
  int m_left [NUM_CH];
  int m_beats[NUM_CH];
  bit m_lvl  [NUM_CH];
  bit m_tk   [NUM_CH];

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic model_cycle(input bit rn, input bit en, input bit sy, input bit wr,
                             input int ch, input int val);
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit;
      hit = wr && (ch == c);
      if (!rn) begin
        m_len[c] = DEFAULT_DIV; m_next[c] = DEFAULT_DIV; m_left[c] = DEFAULT_DIV;
        m_lvl[c] = 0; m_tk[c] = 0; m_beats[c] = 0;
      end else if (sy) begin
        if (hit) m_next[c] = val;
        m_len[c] = m_next[c]; m_left[c] = m_len[c];
        m_lvl[c] = 0; m_tk[c] = 0; m_beats[c] = 0;
      end else begin
        if (hit) m_next[c] = val;
        m_tk[c] = 0;
        if (m_len[c] == 0) begin
          m_lvl[c] = 0;
          if (hit && val != 0) begin
            m_len[c] = val; m_left[c] = val;
          end
        end else if (en) begin
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            m_tk[c]    = 1;
            m_beats[c] = (m_beats[c] + 1) % 65536;
            m_len[c]   = m_next[c];
            m_left[c]  = m_len[c];
            m_lvl[c]   = (m_len[c] == 0) ? 1'b0 : !m_lvl[c];
          end
        end
      end
    end
  endtask

  function automatic logic [W-1:0] pack_expected();
    logic [W-1:0] e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e[c]          = m_tk[c];
      e[NUM_CH + c] = m_lvl[c];
`ifdef TICK_COUNT_EN
      e[2*NUM_CH + 16*c +: 16] = 16'(m_beats[c]);
`endif
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Apply one cycle of inputs at the falling edge and queue the prediction for the next rising edge.
  task automatic step(input bit rn, input bit en, input bit sy, input bit wr,
                      input int ch, input int val);
    resetn  = rn;
    enable  = en;
    sync    = sy;
    div_wr  = wr;
    div_ch  = CH_W'(ch);
    div_val = CNT_W'(val);
    model_cycle(rn, en, sy, wr, ch, val);
    exp_q.push_back(pack_expected());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // One expectation is retired per rising edge, sampled just after the edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (tick !== e[NUM_CH-1:0]) begin
          errors++;
          $display("FAIL tick @%0t: got %b expected %b", $time, tick, e[NUM_CH-1:0]);
        end
        checks++;
        if (out_clk !== e[2*NUM_CH-1:NUM_CH]) begin
          errors++;
          $display("FAIL out_clk @%0t: got %b expected %b", $time, out_clk, e[2*NUM_CH-1:NUM_CH]);
        end
`ifdef TICK_COUNT_EN
        checks++;
        if (tick_cnt !== e[W-1:2*NUM_CH]) begin
          errors++;
          $display("FAIL tick_cnt @%0t: got %h expected %h", $time, tick_cnt, e[W-1:2*NUM_CH]);
        end
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    @(negedge clk);
    // Reset and free-running default divisor of 4.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    run(20);
    // Retune ch1 to 3 in the middle of a half-period.
    run(1);
    step(1, 1, 0, 1, 1, 3);
    run(15);
    // Halt ch0, then restart it at 5.
    step(1, 1, 0, 1, 0, 0);
    run(10);
    step(1, 1, 0, 1, 0, 5);
    run(14);
    // Freeze all counters for 10 cycles.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    run(10);
    // Sync on the exact cycle of ch0's terminal count, together with a ch0 write of 6.
    waited = 0;
    while (!(m_len[0] != 0 && m_left[0] == 1) && waited < 20) begin
      run(1);
      waited++;
    end
    step(1, 1, 1, 1, 0, 6);
    run(15);
    // Out-of-range channel write must change nothing.
    step(1, 1, 0, 1, 3, 2);
    run(12);
    // Divisor of 1 gives a tick every cycle.
    step(1, 1, 0, 1, 2, 1);
    run(8);
`ifdef TICK_COUNT_EN
    // Long run at divisor 1 to wrap the 16-bit tick counter.
    step(1, 1, 1, 1, 0, 1);
    run(65537);
`endif
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit en, sy, wr;
      int ch, val;
      en  = ($urandom_range(0, 9) != 0);
      sy  = ($urandom_range(0, 59) == 0);
      wr  = ($urandom_range(0, 9) == 0);
      ch  = $urandom_range(0, 3);
      val = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 7);
      step(1, en, sy, wr, ch, val);
    end
    step(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
